// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg
// Shared definitions for the data-memory arbiter: port indices, lock state
// encoding, the read-return tag layout and the default lock burst limit.
package dm_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEFAULT_MAX_LOCK = 16;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Outstanding read: which port gets the data that memory returns next cycle.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2
// Two-requester round-robin picker. A registered 'last' pointer remembers the
// most recent winner; on a tie the other port wins. A force request overrides
// the rotation, but only when the forced port is actually requesting.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (last resets to port 1)
//   req[1:0]        requests (bit 0 = CPU, bit 1 = debug)
//   force_en        give priority to force_port this cycle
//   force_port      port to favour when force_en is set
//   gnt[1:0]        one-hot grant, combinational
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       force_en,
    input  logic       force_port,
    output logic [1:0] gnt
);

    logic last;

    // Winner selection: forced port first, then rotation on ties, else the lone requester.
    always_comb begin
        gnt = 2'b00;
        if (force_en && req[force_port]) begin
            gnt = (force_port == PORT_CPU) ? 2'b01 : 2'b10;
        end else if (req == 2'b11) begin
            gnt = (last == PORT_DBG) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Resetting to the debug port makes the CPU win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= PORT_DBG;
        end else if (gnt[1]) begin
            last <= PORT_DBG;
        end else if (gnt[0]) begin
            last <= PORT_CPU;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
// Shares the single data memory between the CPU load/store path (port 0) and
// an external debug/loader master (port 1). At most one access is granted per
// cycle; the winner drives the memory strobes, address and write data in the
// same cycle, and read data returns one cycle later tagged to its owner.
// Optional feature: define DM_ARB_LOCK_EN to add p1_lock and a lock FSM that
// lets port 1 hold the memory for up to MAX_LOCK consecutive grants, after
// which the CPU is given the next cycle if it is waiting.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   pN_req/we/addr/wdata      requester N access (we=1 write)
//   p1_lock                   (DM_ARB_LOCK_EN only) port 1 burst lock
//   pN_gnt                    request accepted this cycle
//   pN_rvalid, rdata          read return, one cycle after a read grant
//   cpu_stall                 CPU requesting but denied
//   mem_rden/wren/addr/wdata  memory inputs; mem_q memory read data
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = DEFAULT_MAX_LOCK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
`ifdef DM_ARB_LOCK_EN
    input  logic              p1_lock,
`endif
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_max_lock_range
        $error("dm_arbiter: MAX_LOCK must be within 1..255");
    end

    logic [1:0] req_vec;
    logic [1:0] gnt;
    logic       force_en;
    logic       force_port;
    rd_tag_t    rd_pend;

    // Requests are masked during reset so every output sits at 0 while rst is low.
    assign req_vec = {p1_req, p0_req} & {2{rst}};

    rr_arb2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req_vec),
        .force_en   (force_en),
        .force_port (force_port),
        .gnt        (gnt)
    );

`ifdef DM_ARB_LOCK_EN
    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    lock_state_t state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        force_cpu, force_cpu_nxt;
    logic        hold;

    assign hold = p1_req & p1_lock;

    // force_cpu is the one-cycle payback after a burst hit MAX_LOCK.
    always_comb begin
        force_en   = 1'b0;
        force_port = PORT_CPU;
        if (force_cpu) begin
            force_en   = 1'b1;
            force_port = PORT_CPU;
        end else if (state == LOCKED && hold) begin
            force_en   = 1'b1;
            force_port = PORT_DBG;
        end
    end

    // cnt counts port 1 grants in the current burst, including the one that locked.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        force_cpu_nxt = 1'b0;
        case (state)
            FREE: begin
                if (gnt[1] && p1_lock) begin
                    if (MAX_LOCK_C == 8'd1) begin
                        force_cpu_nxt = 1'b1;
                    end else begin
                        state_nxt = LOCKED;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (hold) begin
                    if (cnt + 8'd1 == MAX_LOCK_C) begin
                        state_nxt     = FREE;
                        cnt_nxt       = 8'd0;
                        force_cpu_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end else begin
                    state_nxt = FREE;
                    cnt_nxt   = 8'd0;
                end
            end
            default: begin
                state_nxt = FREE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FREE;
            cnt       <= 8'd0;
            force_cpu <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            force_cpu <= force_cpu_nxt;
        end
    end
`else
    assign force_en   = 1'b0;
    assign force_port = PORT_CPU;
`endif

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign cpu_stall = p0_req & ~gnt[0] & rst;

    // Memory request mux; everything is 0 when nobody is granted.
    always_comb begin
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_rden  = ~p0_we;
            mem_wren  = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (gnt[1]) begin
            mem_rden  = ~p1_we;
            mem_wren  = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= '0;
        end else begin
            rd_pend.valid <= mem_rden;
            rd_pend.port  <= gnt[1];
        end
    end

    assign p0_rvalid = rd_pend.valid & (rd_pend.port == PORT_CPU);
    assign p1_rvalid = rd_pend.valid & (rd_pend.port == PORT_DBG);
    assign rdata     = rd_pend.valid ? mem_q : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
// Drives dm_arbiter against a small behavioural memory. Expected grants and
// memory strobes come from a reference arbitration model; expected read data
// comes from a reference copy of memory and is queued when the read is
// granted, then compared when rvalid appears.
module tb_dm_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 4;
`ifdef DM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p1_lock = 1'b0;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, cpu_stall;
    logic          mem_rden, mem_wren;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_q = '0;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int   total = 0;
    int   bad   = 0;

    logic m_last, m_locked, m_force0;
    int   m_cnt;
    logic obs_g0, obs_g1, obs_stall;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .p0_we     (p0_we),
        .p1_we     (p1_we),
        .p0_addr   (p0_addr),
        .p1_addr   (p1_addr),
        .p0_wdata  (p0_wdata),
        .p1_wdata  (p1_wdata),
`ifdef DM_ARB_LOCK_EN
        .p1_lock   (p1_lock),
`endif
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_rvalid (p1_rvalid),
        .rdata     (rdata),
        .cpu_stall (cpu_stall),
        .mem_rden  (mem_rden),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_q     (mem_q)
    );

    // Behavioural data memory: writes commit at the edge, reads return next cycle.
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_rden) mem_q <= mem[mem_addr[7:0]];
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_bits"}, {57'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
                                     cpu_stall, mem_rden, mem_wren}, 64'd0);
        checkOutput({tag, "_addr"}, 64'(mem_addr), 64'd0);
        checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
    endtask

    task automatic modelReset();
        sb.delete();
        m_last   = 1'b1;
        m_locked = 1'b0;
        m_force0 = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic dropInputs();
        p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0; p1_lock = 1'b0;
    endtask

    task automatic resetDut();
        dropInputs();
        rst = 1'b0;
        modelReset();
        @(posedge clk); #1;
        checkZeros("reset");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // One bus cycle; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic r0, input logic we0, input logic [7:0] a0,
                                 input logic [DW-1:0] d0, input logic r1, input logic we1,
                                 input logic [7:0] a1, input logic [DW-1:0] d1,
                                 input logic lk, input bit pulse);
        logic          e0, e1, erd, ewr, nf;
        logic [7:0]    ea;
        logic [DW-1:0] ed;
        exp_t          e;
        p0_req = r0; p0_we = we0; p0_addr = AW'(a0); p0_wdata = d0;
        p1_req = r1; p1_we = we1; p1_addr = AW'(a1); p1_wdata = d1;
        p1_lock = lk;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("p0_rvalid", 64'(p0_rvalid), 64'(e.port == 1'b0));
            checkOutput("p1_rvalid", 64'(p1_rvalid), 64'(e.port == 1'b1));
            checkOutput("rdata", 64'(rdata), 64'(e.data));
        end else begin
            checkOutput("p0_rvalid_idle", 64'(p0_rvalid), 64'd0);
            checkOutput("p1_rvalid_idle", 64'(p1_rvalid), 64'd0);
        end
        e0 = 1'b0; e1 = 1'b0;
        if (LOCK_EN && m_force0 && r0) e0 = 1'b1;
        else if (LOCK_EN && m_locked && r1 && lk) e1 = 1'b1;
        else if (r0 && r1) begin
            if (m_last) e0 = 1'b1; else e1 = 1'b1;
        end else begin
            e0 = r0; e1 = r1;
        end
        erd = (e0 && !we0) || (e1 && !we1);
        ewr = (e0 && we0) || (e1 && we1);
        ea  = e0 ? a0 : (e1 ? a1 : 8'd0);
        ed  = e0 ? d0 : (e1 ? d1 : '0);
        checkOutput("p0_gnt", 64'(p0_gnt), 64'(e0));
        checkOutput("p1_gnt", 64'(p1_gnt), 64'(e1));
        checkOutput("cpu_stall", 64'(cpu_stall), 64'(r0 && !e0));
        checkOutput("mem_rden", 64'(mem_rden), 64'(erd));
        checkOutput("mem_wren", 64'(mem_wren), 64'(ewr));
        checkOutput("mem_addr", 64'(mem_addr), 64'(ea));
        checkOutput("mem_wdata", 64'(mem_wdata), 64'(ed));
        obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_stall = cpu_stall;
        if (erd) begin
            e.port = e1;
            e.data = ref_mem[ea];
            sb.push_back(e);
        end
        if (pulse) begin
            #1 rst = 1'b0;
            #1 checkZeros("midread_rst");
            modelReset();
            @(posedge clk); #1;
            rst = 1'b1;
        end else begin
            @(posedge clk);
            if (ewr) ref_mem[ea] = ed;
            if (e1) m_last = 1'b1; else if (e0) m_last = 1'b0;
            if (LOCK_EN) begin
                nf = 1'b0;
                if (!m_locked) begin
                    if (e1 && lk) begin
                        if (ML == 1) nf = 1'b1;
                        else begin m_locked = 1'b1; m_cnt = 1; end
                    end
                end else if (r1 && lk) begin
                    if (m_cnt + 1 == ML) begin m_locked = 1'b0; m_cnt = 0; nf = 1'b1; end
                    else m_cnt++;
                end else begin
                    m_locked = 1'b0; m_cnt = 0;
                end
                m_force0 = nf;
            end
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i * 17 + 3);
            ref_mem[i] = 32'(i * 17 + 3);
        end
        mem[5] = 32'h1234; ref_mem[5] = 32'h1234;
        resetDut();

        $display("[TB] single CPU read");
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_p0_gnt", 64'(obs_g0), 64'd1);
        idle(1);

        $display("[TB] contention, p0 reads and p1 writes");
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 8'(10 + i), 0, 1, 1, 8'(20 + i), 32'hB000 + 32'(i), 0, 0);
            checkOutput($sformatf("t2_g0_c%0d", i + 1), 64'(obs_g0), 64'((i % 2) == 0));
            checkOutput($sformatf("t2_stall_c%0d", i + 1), 64'(obs_stall), 64'((i % 2) == 1));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'(20 + i), 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        $display("[TB] debug write then CPU read of same word");
        applyStimulus(0, 0, 0, 0, 1, 1, 7, 32'hAA, 0, 0);
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

`ifdef DM_ARB_LOCK_EN
        $display("[TB] locked burst");
        resetDut();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 8'(40 + i), 0, 1, 1, 8'(50 + i), 32'hC000 + 32'(i), 1, 0);
            checkOutput($sformatf("t4_g1_c%0d", i), 64'(obs_g1), 64'(i >= 1 && i <= 4));
        end
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 8'(40 + i), 0, 1, 1, 8'(60 + i), 32'hC100 + 32'(i), 0, 0);
        idle(1);
`endif

        $display("[TB] reset during a read");
        resetDut();
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 3, 0, 1, 0, 4, 0, 0, 0);
        checkOutput("t5_tie_p0", 64'(obs_g0), 64'd1);
        idle(1);

        $display("[TB] debug request withdrawn while denied");
        resetDut();
        applyStimulus(1, 0, 2, 0, 1, 1, 30, 32'hDEAD, 0, 0);
        checkOutput("t6_p1_denied", 64'(obs_g1), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 30, 32'hDEAD, 0, 0);
        checkOutput("t6_p1_dropped", 64'(obs_g1), 64'd0);
        applyStimulus(1, 0, 30, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 1)), 0);
        end
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 8'(i), 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
